// File: rtl/seq_detector_prog_if.sv
// Configuration, serial stream and status bundle for the programmable sequence detector.
// master drives pattern setup and the qualified bit stream; slave is the detector itself.
interface seq_detector_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
);
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               enable;
  logic               data_valid;
  logic               data_in;
  logic               match;
  logic [1:0]         state;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output enable, data_valid, data_in,
    input  match, state, match_count
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input  enable, data_valid, data_in,
    output match, state, match_count
  );
endinterface

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial sequence detector with a Mealy match pulse.
// Define MATCH_CNT_EN to build the saturating match counter; otherwise match_count reads 0.
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               rst_n,
  seq_detector_prog_if.slave bus
);
  localparam int FILL_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HUNT = 2'b01,
    LOCK = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [FILL_W-1:0]  fill_q, fill_d;

  logic               cfg_take;
  logic               accepted;
  logic               window_eq;
  logic               hit;
  logic [MAX_LEN:0]   window;
  logic [MAX_LEN:0]   mask;

  assign cfg_take = bus.enable & bus.cfg_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      hist_q  <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      fill_q  <= fill_d;
    end
  end

  // Window is the newest len bits including the bit on data_in right now;
  // masking keeps the compare independent of stale history above len.
  always_comb begin
    accepted = bus.enable & bus.data_valid & (state_q != IDLE) & ~bus.cfg_load;
    window   = {hist_q, bus.data_in};
    mask     = '0;
    for (int i = 0; i <= MAX_LEN; i++) begin
      mask[i] = ($unsigned(i) < 32'(len_q));
    end
    window_eq = (((window ^ {1'b0, pat_q}) & mask) == '0);
    hit       = accepted & ((32'(fill_q) + 32'd1) >= 32'(len_q)) & window_eq;
  end

  assign bus.match = hit;
  assign bus.state = state_q;

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (cfg_take) begin
      pat_d  = bus.cfg_pattern;
      len_d  = bus.cfg_len;
      ovl_d  = bus.cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (accepted) begin
      if (hit && !ovl_q) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = {hist_q[MAX_LEN-2:0], bus.data_in};
        fill_d = (fill_q == FILL_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
      end
    end
    // State is a pure function of the next config and fill, so len==1 lands in LOCK.
    if ((len_d == '0) || (32'(len_d) > 32'(MAX_LEN))) begin
      state_d = IDLE;
    end else if ((32'(fill_d) + 32'd1) < 32'(len_d)) begin
      state_d = HUNT;
    end else begin
      state_d = LOCK;
    end
  end

`ifdef MATCH_CNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (cfg_take) begin
      count_q <= '0;
    end else if (hit && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bus.match_count = count_q;
`else
  assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: overlap/non-overlap, qualifiers, length boundaries,
// counter saturation (4-bit counter) and asynchronous reset.
module tb_seq_detector_prog;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 4;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_HUNT = 2'b01;
  localparam logic [1:0] S_LOCK = 2'b10;
`ifdef MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  seq_detector_prog_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] expCount(input int n);
    int sat;
    sat = (n > 15) ? 15 : n;
    return CNT_EN ? 32'(sat) : 32'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Called just after a falling edge: drive one cycle, check the Mealy output, then the registered state.
  task automatic applyStimulus(input logic en, input logic dv, input logic din,
                               input logic exp_match, input logic [1:0] exp_state, input string tag);
    bus.cfg_load   = 1'b0;
    bus.enable     = en;
    bus.data_valid = dv;
    bus.data_in    = din;
    #1 checkOutput({tag, "_match"}, 32'(bus.match), 32'(exp_match));
    @(negedge clk);
    #1 checkOutput({tag, "_state"}, 32'(bus.state), 32'(exp_state));
  endtask

  task automatic loadConfig(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                            input logic dv, input logic din, input logic [1:0] exp_state, input string tag);
    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    bus.enable      = 1'b1;
    bus.data_valid  = dv;
    bus.data_in     = din;
    #1 checkOutput({tag, "_match"}, 32'(bus.match), 32'd0);
    @(negedge clk);
    bus.cfg_load = 1'b0;
    #1 checkOutput({tag, "_state"}, 32'(bus.state), 32'(exp_state));
    checkOutput({tag, "_count"}, 32'(bus.match_count), expCount(0));
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    bus.enable      = 1'b0;
    bus.data_valid  = 1'b0;
    bus.data_in     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_state", 32'(bus.state), 32'(S_IDLE));
    checkOutput("rst_match", 32'(bus.match), 32'd0);
    checkOutput("rst_count", 32'(bus.match_count), 32'd0);
    rst_n = 1'b1;

    // Never configured: stays idle, no matches
    applyStimulus(1, 1, 1, 0, S_IDLE, "nocfg1");
    applyStimulus(1, 1, 1, 0, S_IDLE, "nocfg2");
    applyStimulus(1, 1, 0, 0, S_IDLE, "nocfg3");

    // 11011 overlapping, stream 1,1,0,1,1,0,1,1
    loadConfig(8'b0001_1011, 4'd5, 1'b1, 1'b0, 1'b0, S_HUNT, "ovl_load");
    applyStimulus(1, 1, 1, 0, S_HUNT, "ovl_b1");
    applyStimulus(1, 1, 1, 0, S_HUNT, "ovl_b2");
    applyStimulus(1, 1, 0, 0, S_HUNT, "ovl_b3");
    applyStimulus(1, 1, 1, 0, S_LOCK, "ovl_b4");
    applyStimulus(1, 1, 1, 1, S_LOCK, "ovl_b5");
    applyStimulus(1, 1, 0, 0, S_LOCK, "ovl_b6");
    applyStimulus(1, 1, 1, 0, S_LOCK, "ovl_b7");
    applyStimulus(1, 1, 1, 1, S_LOCK, "ovl_b8");
    checkOutput("ovl_count", 32'(bus.match_count), expCount(2));

    // Same pattern, non-overlapping
    loadConfig(8'b0001_1011, 4'd5, 1'b0, 1'b0, 1'b0, S_HUNT, "nov_load");
    applyStimulus(1, 1, 1, 0, S_HUNT, "nov_b1");
    applyStimulus(1, 1, 1, 0, S_HUNT, "nov_b2");
    applyStimulus(1, 1, 0, 0, S_HUNT, "nov_b3");
    applyStimulus(1, 1, 1, 0, S_LOCK, "nov_b4");
    applyStimulus(1, 1, 1, 1, S_HUNT, "nov_b5");
    applyStimulus(1, 1, 0, 0, S_HUNT, "nov_b6");
    applyStimulus(1, 1, 1, 0, S_HUNT, "nov_b7");
    applyStimulus(1, 1, 1, 0, S_HUNT, "nov_b8");
    checkOutput("nov_count", 32'(bus.match_count), expCount(1));

    // Overlap stream with invalid and disabled cycles interleaved
    loadConfig(8'b0001_1011, 4'd5, 1'b1, 1'b0, 1'b0, S_HUNT, "qual_load");
    applyStimulus(1, 1, 1, 0, S_HUNT, "qual_b1");
    applyStimulus(1, 1, 1, 0, S_HUNT, "qual_b2");
    applyStimulus(1, 0, 0, 0, S_HUNT, "qual_nv1");
    applyStimulus(1, 1, 0, 0, S_HUNT, "qual_b3");
    applyStimulus(1, 1, 1, 0, S_LOCK, "qual_b4");
    applyStimulus(0, 1, 1, 0, S_LOCK, "qual_dis1");
    applyStimulus(1, 1, 1, 1, S_LOCK, "qual_b5");
    applyStimulus(1, 1, 0, 0, S_LOCK, "qual_b6");
    applyStimulus(1, 0, 1, 0, S_LOCK, "qual_nv2");
    applyStimulus(1, 1, 1, 0, S_LOCK, "qual_b7");
    applyStimulus(0, 1, 1, 0, S_LOCK, "qual_dis2");
    applyStimulus(1, 1, 1, 1, S_LOCK, "qual_b8");
    checkOutput("qual_count", 32'(bus.match_count), expCount(2));
    applyStimulus(1, 1, 0, 0, S_LOCK, "qual_b9");
    applyStimulus(1, 1, 1, 0, S_LOCK, "qual_b10");

    // Reload on the bit that would complete 11011: bit discarded, counter cleared
    loadConfig(8'b0001_1011, 4'd5, 1'b1, 1'b1, 1'b1, S_HUNT, "coll_load");
    applyStimulus(1, 1, 1, 0, S_HUNT, "coll_b1");
    applyStimulus(1, 1, 1, 0, S_HUNT, "coll_b2");
    applyStimulus(1, 1, 0, 0, S_HUNT, "coll_b3");
    applyStimulus(1, 1, 1, 0, S_LOCK, "coll_b4");

    // Single-bit pattern, non-overlapping
    loadConfig(8'h01, 4'd1, 1'b0, 1'b0, 1'b0, S_LOCK, "len1_load");
    applyStimulus(1, 1, 1, 1, S_LOCK, "len1_b1");
    applyStimulus(1, 1, 0, 0, S_LOCK, "len1_b2");
    applyStimulus(1, 1, 1, 1, S_LOCK, "len1_b3");
    applyStimulus(1, 1, 1, 1, S_LOCK, "len1_b4");
    applyStimulus(1, 0, 1, 0, S_LOCK, "len1_nv");
    applyStimulus(1, 1, 0, 0, S_LOCK, "len1_b5");
    checkOutput("len1_count", 32'(bus.match_count), expCount(3));

    // Full-length all-ones pattern against a run of ones
    loadConfig(8'hFF, 4'd8, 1'b1, 1'b0, 1'b0, S_HUNT, "max_load");
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1, 1, 1, (k >= 8), (k < 7) ? S_HUNT : S_LOCK, $sformatf("max_b%0d", k));
    end
    checkOutput("max_count", 32'(bus.match_count), expCount(3));

    // Illegal lengths keep the detector idle
    loadConfig(8'hFF, 4'd0, 1'b1, 1'b0, 1'b0, S_IDLE, "len0_load");
    applyStimulus(1, 1, 1, 0, S_IDLE, "len0_b1");
    applyStimulus(1, 1, 1, 0, S_IDLE, "len0_b2");
    loadConfig(8'hFF, 4'd9, 1'b1, 1'b0, 1'b0, S_IDLE, "len9_load");
    applyStimulus(1, 1, 1, 0, S_IDLE, "len9_b1");
    applyStimulus(1, 1, 1, 0, S_IDLE, "len9_b2");

    // Counter saturation
    loadConfig(8'h01, 4'd1, 1'b1, 1'b0, 1'b0, S_LOCK, "sat_load");
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1, 1, 1, 1, S_LOCK, $sformatf("sat_b%0d", k));
      checkOutput($sformatf("sat_cnt%0d", k), 32'(bus.match_count), expCount(k));
    end

    // Asynchronous reset in the middle of a matching cycle
    bus.enable     = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in    = 1'b1;
    #1 checkOutput("arst_pre_match", 32'(bus.match), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_state", 32'(bus.state), 32'(S_IDLE));
    checkOutput("arst_match", 32'(bus.match), 32'd0);
    checkOutput("arst_count", 32'(bus.match_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 1, 1, 0, S_IDLE, "post_rst1");
    applyStimulus(1, 1, 1, 0, S_IDLE, "post_rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
